line_select_decoder: RTL and testbench

- Decodes a 4-bit address into a 16-line active-low select vector `d_n`. This is the reverse of the 16-line active-low encoder that produces `address`.
- Each accepted address drives its line low for a fixed number of cycles, then releases it.
- A scan mode walks all 16 lines in order. It sits between the address source and the 16-line request bus, which it regenerates.

---
 rtl/line_sel_pkg.sv | 16 +
 rtl/line_select_decoder_onehot_n_decode.sv | 21 ++
 rtl/line_select_decoder.sv | 136 +++++++++++++
 tb/tb_line_select_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_sel_pkg.sv
// Shared types and constants for the line select decoder.
// State encoding, default geometry and the idle bus value.
package line_sel_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int LINES_DEF  = 16;

  localparam logic [LINES_DEF-1:0] IDLE_BUS = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    SCAN_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/line_select_decoder_onehot_n_decode.sv
// Combinational active-low one-hot decoder with enable.
// All lines read high when disabled.
module onehot_n_decode #(
  parameter int ADDR_W = 4,
  parameter int LINES  = 16
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [LINES-1:0]  d_n_o
);

  always_comb begin
    d_n_o = '1;
    for (int i = 0; i < LINES; i++) begin
      if (en_i && addr_i == ADDR_W'(i)) begin
        d_n_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/line_select_decoder.sv
// Address-to-line active-low select with timed hold and scan mode.
// Outputs are registered one cycle behind the control state.
module line_select_decoder
  import line_sel_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINES    = LINES_DEF,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic              c,
  input  logic              s,
  output logic [LINES-1:0]  d_n,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] LAST = 8'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINES-1:0]  d_n_q, d_n_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;
  logic              accept;
  logic              last;
  logic [ADDR_W-1:0] line;

  // s and c both block a transfer in the cycle they are seen
  assign addr_ready = rdy_q & ~s & ~c;
  assign accept     = addr_ready & addr_valid;
  assign last       = (cnt_q == LAST);
  assign line       = (state_q == SCAN_HOLD) ? ptr_q : addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    if (c) begin
      state_d = IDLE;
      cnt_d   = '0;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s) begin
            state_d = SCAN_HOLD;
            ptr_d   = '0;
            cnt_d   = '0;
          end else if (accept) begin
            state_d = HOLD;
            addr_d  = addr_in;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        SCAN_HOLD: begin
          if (last) begin
            cnt_d = '0;
            ptr_d = ptr_q + ADDR_W'(1);
            if (!s) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy_d    = ~c & (state_q != IDLE);
    done_d    = busy_d & last;
    rdy_d     = (state_q == IDLE) & (state_d == IDLE);
    address_d = busy_d ? line : address_q;
  end

  onehot_n_decode #(
    .ADDR_W (ADDR_W),
    .LINES  (LINES)
  ) u_dec (
    .en_i   (busy_d),
    .addr_i (line),
    .d_n_o  (d_n_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      d_n_q     <= '1;
      address_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      d_n_q     <= d_n_d;
      address_q <= address_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
    end
  end

  assign d_n     = d_n_q;
  assign address = address_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_line_select_decoder.sv
// Scoreboard bench for line_select_decoder.
// Second instance covers the single-cycle hold boundary.
module tb_line_select_decoder;
  import line_sel_pkg::*;

  typedef struct packed {
    logic [15:0] d_n;
    logic        busy;
    logic        done;
    logic        rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  addr_in = '0;
  logic        addr_valid = 1'b0;
  logic        c = 1'b0;
  logic        s = 1'b0;
  logic        addr_ready;
  logic [15:0] d_n;
  logic [3:0]  address;
  logic        busy;
  logic        done;

  logic [3:0]  addr_in1 = '0;
  logic        valid1 = 1'b0;
  logic        c1 = 1'b0;
  logic        s1 = 1'b0;
  logic        ready1;
  logic [15:0] d_n1;
  logic [3:0]  address1;
  logic        busy1;
  logic        done1;

  int   tests = 0;
  int   failed = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  line_select_decoder #(.ADDR_W(4), .LINES(16), .HOLD_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .c(c), .s(s), .d_n(d_n), .address(address),
    .busy(busy), .done(done)
  );

  line_select_decoder #(.ADDR_W(4), .LINES(16), .HOLD_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in1),
    .addr_valid(valid1), .addr_ready(ready1),
    .c(c1), .s(s1), .d_n(d_n1), .address(address1),
    .busy(busy1), .done(done1)
  );

  function automatic exp_t mk(logic [15:0] d, logic b, logic dn, logic r);
    exp_t e;
    e.d_n  = d;
    e.busy = b;
    e.done = dn;
    e.rdy  = r;
    return e;
  endfunction

  function automatic logic [15:0] sel(int k);
    logic [15:0] one;
    one = 16'h1;
    return ~(one << k);
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (d_n !== IDLE_BUS || busy !== 1'b0 || done !== 1'b0 ||
        address !== 4'd0 || addr_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset: d_n=%h busy=%b done=%b addr=%h rdy=%b, want ffff 0 0 0 0",
               d_n, busy, done, address, addr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (addr_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_pre_edge: rdy=%b, want 0", addr_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (addr_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_release: rdy=%b, want 1", addr_ready);
    end
  endtask

  task automatic test_single();
    exp_t e;
    addr_in    = 4'd0;
    addr_valid = 1'b1;
    tests++;
    if (addr_ready !== 1'b1) begin
      failed++;
      $display("FAIL single_ready: rdy=%b, want 1", addr_ready);
    end
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 4; i++)
      exp_q.push_back(mk(sel(0), 1'b1, i == 4, 1'b0));
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      addr_valid = 1'b0;
      e = exp_q.pop_front();
      tests++;
      if (d_n !== e.d_n || busy !== e.busy || done !== e.done ||
          addr_ready !== e.rdy) begin
        failed++;
        $display("FAIL single[%0d]: got %h %b %b %b, want %h %b %b %b",
                 i, d_n, busy, done, addr_ready, e.d_n, e.busy, e.done, e.rdy);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    addr_in    = 4'd15;
    addr_valid = 1'b1;
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 4; i++)
        exp_q.push_back(mk(sel(15), 1'b1, i == 4, 1'b0));
      exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b1));
      if (k == 0) exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests++;
      if (d_n !== e.d_n || busy !== e.busy || done !== e.done ||
          addr_ready !== e.rdy || (busy && address !== 4'd15)) begin
        failed++;
        $display("FAIL b2b[%0d]: got %h %b %b %b a=%h, want %h %b %b %b a=f",
                 i, d_n, busy, done, addr_ready, address,
                 e.d_n, e.busy, e.done, e.rdy);
      end
      tests++;
      if ($countones(~d_n) > 1) begin
        failed++;
        $display("FAIL b2b_onehot[%0d]: d_n=%h, want at most one low bit", i, d_n);
      end
      if (i == 11) addr_valid = 1'b0;
    end
  endtask

  task automatic test_scan_wrap();
    exp_t e;
    int   dones;
    dones = 0;
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 68; i++)
      exp_q.push_back(mk(sel(((i - 1) / 4) % 16), 1'b1, ((i - 1) % 4) == 3, 1'b0));
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b1));
    s = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests++;
      if (d_n !== e.d_n || busy !== e.busy || done !== e.done ||
          addr_ready !== e.rdy) begin
        failed++;
        $display("FAIL scan[%0d]: got %h %b %b %b, want %h %b %b %b",
                 i, d_n, busy, done, addr_ready, e.d_n, e.busy, e.done, e.rdy);
      end
      if (i >= 1 && i <= 64 && done === 1'b1) dones++;
      if (i == 66) s = 1'b0;
    end
    tests++;
    if (dones !== 16) begin
      failed++;
      $display("FAIL scan_dones: got %0d, want 16", dones);
    end
  endtask

  task automatic test_clear();
    exp_t e;
    addr_in    = 4'd7;
    addr_valid = 1'b1;
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(sel(7), 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(sel(7), 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    for (int i = 5; i <= 8; i++)
      exp_q.push_back(mk(sel(0), 1'b1, i == 8, 1'b0));
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests++;
      if (d_n !== e.d_n || busy !== e.busy || done !== e.done ||
          addr_ready !== e.rdy) begin
        failed++;
        $display("FAIL clear[%0d]: got %h %b %b %b, want %h %b %b %b",
                 i, d_n, busy, done, addr_ready, e.d_n, e.busy, e.done, e.rdy);
      end
      if (i == 0) begin
        addr_valid = 1'b0;
        s = 1'b1;
      end
      if (i == 2) c = 1'b1;
      if (i == 3) c = 1'b0;
      if (i == 6) s = 1'b0;
    end
  endtask

  task automatic test_scan_vs_request();
    exp_t e;
    addr_in    = 4'd9;
    addr_valid = 1'b1;
    s          = 1'b1;
    #1;
    tests++;
    if (addr_ready !== 1'b0) begin
      failed++;
      $display("FAIL svr_ready: rdy=%b, want 0", addr_ready);
    end
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 4; i++)
      exp_q.push_back(mk(sel(0), 1'b1, i == 4, 1'b0));
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests++;
      if (d_n !== e.d_n || busy !== e.busy || done !== e.done ||
          addr_ready !== e.rdy || (busy && address !== 4'd0)) begin
        failed++;
        $display("FAIL svr[%0d]: got %h %b %b %b a=%h, want %h %b %b %b a=0",
                 i, d_n, busy, done, addr_ready, address,
                 e.d_n, e.busy, e.done, e.rdy);
      end
      if (i == 1) begin
        s = 1'b0;
        addr_valid = 1'b0;
      end
    end
  endtask

  task automatic test_hold1();
    exp_t e;
    addr_in1 = 4'd3;
    valid1   = 1'b1;
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(sel(3), 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      valid1 = 1'b0;
      e = exp_q.pop_front();
      tests++;
      if (d_n1 !== e.d_n || busy1 !== e.busy || done1 !== e.done ||
          ready1 !== e.rdy) begin
        failed++;
        $display("FAIL hold1[%0d]: got %h %b %b %b, want %h %b %b %b",
                 i, d_n1, busy1, done1, ready1, e.d_n, e.busy, e.done, e.rdy);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    addr_in    = 4'd5;
    addr_valid = 1'b1;
    exp_q.push_back(mk(IDLE_BUS, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(sel(5), 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(sel(5), 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      addr_valid = 1'b0;
      e = exp_q.pop_front();
      tests++;
      if (d_n !== e.d_n || busy !== e.busy || done !== e.done ||
          addr_ready !== e.rdy) begin
        failed++;
        $display("FAIL rmid[%0d]: got %h %b %b %b, want %h %b %b %b",
                 i, d_n, busy, done, addr_ready, e.d_n, e.busy, e.done, e.rdy);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (d_n !== IDLE_BUS || busy !== 1'b0 || done !== 1'b0 ||
        address !== 4'd0 || addr_ready !== 1'b0) begin
      failed++;
      $display("FAIL rmid_async: d_n=%h busy=%b done=%b addr=%h rdy=%b, want ffff 0 0 0 0",
               d_n, busy, done, address, addr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (addr_ready !== 1'b1 || d_n !== IDLE_BUS) begin
      failed++;
      $display("FAIL rmid_release: rdy=%b d_n=%h, want 1 ffff", addr_ready, d_n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_scan_wrap();
    test_clear();
    test_scan_vs_request();
    test_hold1();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
